ecc_rmw_encoder: RTL and testbench
==================================

ECC_RMW_ENCODER -- requirements
Module: ecc_rmw_encoder

Interface
REQ-001 SHALL have parameter BankSize, default 256, number of bank words.
REQ-002 SHALL have parameter DataWidth, default 32, unprotected data bits; a multiple of 8.
REQ-003 SHALL have parameter ProtWidth, default 7, Hsiao check bits; stored line width LW = DataWidth+ProtWidth.
REQ-004 SHALL have port clk_i input 1, clock.
REQ-005 SHALL have port rst_ni input 1, reset, asynchronous, active-low.
REQ-006 SHALL have port req_i input 1, requester access request.
REQ-007 SHALL have port gnt_o output 1, request accepted this cycle.
REQ-008 SHALL have ports we_i input 1, be_i input DataWidth/8, add_i input clog2(BankSize), wdata_i input DataWidth: write enable, byte enables, word address, write data.
REQ-009 SHALL have ports rvalid_o output 1, rdata_o output DataWidth, err_o output 2: response valid, corrected read data, {uncorrectable, corrected}.
REQ-010 SHALL have ports bank_req_o output 1, bank_we_o output 1, bank_add_o output clog2(BankSize), bank_wdata_o output LW, bank_rdata_i input LW; bank read data arrives exactly one cycle after a read request.
REQ-011 SHALL have ports cnt_clear_i input 1, corr_cnt_o output 16, uncorr_cnt_o output 16: error counters and synchronous clear.

Function
REQ-012 SHALL encode all bank write data with the team Hsiao encoder and decode/correct all bank read data with the team Hsiao corrector (single-bit correct, double-bit detect).
REQ-013 SHALL implement FSM states Idle and Merge; gnt_o = req_i in Idle, gnt_o = 0 in Merge.
REQ-014 Read (req_i & !we_i, Idle): SHALL issue bank read at add_i same cycle; next cycle rvalid_o=1, rdata_o = corrected data, err_o = decoder result.
REQ-015 Full write (be_i all ones, Idle): SHALL issue bank write of encoded wdata_i same cycle; next cycle rvalid_o=1, err_o=00.
REQ-016 Zero-byte write (be_i all zero): SHALL grant, issue no bank access, respond rvalid_o=1, err_o=00 next cycle.
REQ-017 Partial write (other be_i, Idle): SHALL grant, issue bank read at add_i, latch add_i/be_i/wdata_i, move to Merge.
REQ-018 Merge: SHALL decode bank_rdata_i, replace enabled bytes with latched wdata, encode, issue bank write to latched address, assert rvalid_o with err_o = decoder result, return to Idle; total latency 2 cycles grant-to-response.
REQ-019 Merge with uncorrectable error: SHALL suppress bank write (bank_req_o=0), respond err_o=10.
REQ-020 Reads and full writes SHALL be accepted back-to-back every cycle (one response per cycle, in order); a new request is accepted in the cycle Merge completes only on the next Idle cycle.
REQ-021 rdata_o SHALL be 0 when rvalid_o=0 or for write responses.
REQ-022 corr_cnt_o SHALL increment on each response with err_o[0]=1, uncorr_cnt_o on each with err_o[1]=1; both saturate at 16'hFFFF; cnt_clear_i zeroes both and takes priority over same-cycle increment.
REQ-023 bank_add_o, bank_wdata_o SHALL be 0 when bank_req_o=0.

Reset
REQ-024 On rst_ni low: state Idle, gnt_o 0 combinationally until rst_ni high, rvalid_o 0, err_o 00, counters 0, bank_req_o 0, latches cleared.
REQ-025 Reset asserted in Merge SHALL abandon the RMW: no bank write, no response.

Verification
REQ-026 Read clean word 32'hDEADBEEF at addr 5 -> rvalid 1 cycle after gnt, rdata 32'hDEADBEEF, err 00, counters unchanged.
REQ-027 Flip bit 3 of stored line, read -> rdata corrected, err 01, corr_cnt_o 1; stored line unchanged.
REQ-028 Stored 32'h11223344, partial write be=4'b0010 wdata 32'h0000AA00 -> bank write of encode(32'h1122AA44) in Merge cycle, response 2 cycles after gnt, err 00.
REQ-029 Double-bit error stored, partial write be=4'b0001 -> no bank write, err 10, uncorr_cnt_o 1.
REQ-030 Preload corr_cnt_o 16'hFFFF, another corrected read -> stays 16'hFFFF; cnt_clear_i with same-cycle error -> 0.
REQ-031 Assert rst_ni low during Merge -> no bank_we_o pulse, no rvalid_o, all outputs at reset values.

Source files
------------

// File: rtl/ecc_rmw_encoder_if.sv
// Requester-side bus of the ECC read-modify-write bank front end.
// The master drives requests; the slave grants them and returns responses.
interface ecc_rmw_encoder_if #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 8
);
    logic                   req_i;
    logic                   gnt_o;
    logic                   we_i;
    logic [DataWidth/8-1:0] be_i;
    logic [AddrWidth-1:0]   add_i;
    logic [DataWidth-1:0]   wdata_i;
    logic                   rvalid_o;
    logic [DataWidth-1:0]   rdata_o;
    logic [1:0]             err_o;

    modport master (
        output req_i, we_i, be_i, add_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, be_i, add_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/ecc_rmw_encoder.sv
// ECC front end for a single-port memory bank. Every stored line carries
// Hsiao SEC-DED check bits. Reads are corrected on the way out; sub-word
// writes are done as read-modify-write through a one-cycle Merge state.
// Stored line layout: {check[ProtWidth-1:0], data[DataWidth-1:0]}.
module ecc_rmw_encoder #(
    parameter int BankSize  = 256,
    parameter int DataWidth = 32,
    parameter int ProtWidth = 7
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    ecc_rmw_encoder_if.slave                 bus,
    output logic                             bank_req_o,
    output logic                             bank_we_o,
    output logic [$clog2(BankSize)-1:0]      bank_add_o,
    output logic [DataWidth+ProtWidth-1:0]   bank_wdata_o,
    input  logic [DataWidth+ProtWidth-1:0]   bank_rdata_i,
    input  logic                             cnt_clear_i,
    output logic [15:0]                      corr_cnt_o,
    output logic [15:0]                      uncorr_cnt_o
);
    localparam int AddrWidth = $clog2(BankSize);
    localparam int LineWidth = DataWidth + ProtWidth;
    localparam int NumBytes  = DataWidth / 8;

    // Hsiao H-matrix data columns: distinct odd-weight (>=3) check patterns,
    // lowest weight first, ascending value within a weight.
    function automatic logic [DataWidth-1:0][ProtWidth-1:0] gen_cols();
        logic [DataWidth-1:0][ProtWidth-1:0] cols;
        int k;
        int ones;
        cols = '0;
        k    = 0;
        for (int w = 3; w <= ProtWidth; w += 2) begin
            for (int v = 0; v < (1 << ProtWidth); v++) begin
                ones = 0;
                for (int b = 0; b < ProtWidth; b++) begin
                    ones += (v >> b) & 1;
                end
                if (ones == w && k < DataWidth) begin
                    cols[k] = v[ProtWidth-1:0];
                    k++;
                end
            end
        end
        return cols;
    endfunction

    localparam logic [DataWidth-1:0][ProtWidth-1:0] HCols = gen_cols();

    // Check bits are the XOR of the columns of every set data bit.
    function automatic logic [ProtWidth-1:0] calc_check(input logic [DataWidth-1:0] data);
        logic [ProtWidth-1:0] chk;
        chk = '0;
        for (int i = 0; i < DataWidth; i++) begin
            if (data[i]) chk = chk ^ HCols[i];
        end
        return chk;
    endfunction

    typedef enum logic {ST_IDLE, ST_MERGE} state_t;

    state_t                r_state;
    logic [AddrWidth-1:0]  r_add;
    logic [NumBytes-1:0]   r_be;
    logic [DataWidth-1:0]  r_wdata;
    logic                  r_rvalid;
    logic                  r_rd_resp;
    logic [1:0]            r_err;
    logic [15:0]           r_corr_cnt;
    logic [15:0]           r_uncorr_cnt;

    logic                  w_idle_acc;
    logic                  w_be_full;
    logic                  w_be_zero;
    logic [DataWidth-1:0]  w_rd_data;
    logic [ProtWidth-1:0]  w_syndrome;
    logic [DataWidth-1:0]  w_dec_data;
    logic [1:0]            w_dec_err;
    logic                  w_col_hit;
    logic [DataWidth-1:0]  w_merged;
    logic [LineWidth-1:0]  w_full_line;
    logic [LineWidth-1:0]  w_merge_line;

    // Reset must mask the grant combinationally, not just via the state.
    assign w_idle_acc = rst_ni && (r_state == ST_IDLE) && bus.req_i;
    assign w_be_full  = &bus.be_i;
    assign w_be_zero  = ~|bus.be_i;
    assign bus.gnt_o  = w_idle_acc;

    assign w_rd_data  = bank_rdata_i[DataWidth-1:0];
    assign w_syndrome = calc_check(w_rd_data) ^ bank_rdata_i[LineWidth-1:DataWidth];

    // Corrector: odd syndrome matching a data column flips that bit, a
    // weight-1 syndrome is a check-bit hit; anything else is uncorrectable
    // and the raw data bits are passed through untouched.
    always_comb begin
        w_dec_data = w_rd_data;
        w_dec_err  = 2'b00;
        w_col_hit  = 1'b0;
        for (int i = 0; i < DataWidth; i++) begin
            if (w_syndrome == HCols[i]) begin
                w_dec_data[i] = ~w_rd_data[i];
                w_col_hit     = 1'b1;
            end
        end
        if (w_syndrome != '0) begin
            if ((^w_syndrome) && (w_col_hit || ($countones(w_syndrome) == 1))) begin
                w_dec_err = 2'b01;
            end else begin
                w_dec_err  = 2'b10;
                w_dec_data = w_rd_data;
            end
        end
    end

    // Byte merge of latched write data over the corrected old word.
    generate
        for (genvar gi = 0; gi < NumBytes; gi++) begin : g_merge
            assign w_merged[gi*8 +: 8] = r_be[gi] ? r_wdata[gi*8 +: 8] : w_dec_data[gi*8 +: 8];
        end
    endgenerate

    assign w_full_line  = {calc_check(bus.wdata_i), bus.wdata_i};
    assign w_merge_line = {calc_check(w_merged), w_merged};

    // Bank command: reads, full writes and the RMW read leave from Idle; the
    // merged write leaves from Merge unless the old word was uncorrectable.
    always_comb begin
        bank_req_o   = 1'b0;
        bank_we_o    = 1'b0;
        bank_add_o   = '0;
        bank_wdata_o = '0;
        if (w_idle_acc) begin
            if (!bus.we_i) begin
                bank_req_o = 1'b1;
                bank_add_o = bus.add_i;
            end else if (w_be_full) begin
                bank_req_o   = 1'b1;
                bank_we_o    = 1'b1;
                bank_add_o   = bus.add_i;
                bank_wdata_o = w_full_line;
            end else if (!w_be_zero) begin
                bank_req_o = 1'b1;
                bank_add_o = bus.add_i;
            end
        end else if (rst_ni && (r_state == ST_MERGE) && !w_dec_err[1]) begin
            bank_req_o   = 1'b1;
            bank_we_o    = 1'b1;
            bank_add_o   = r_add;
            bank_wdata_o = w_merge_line;
        end
    end

    // Control FSM with registered response flags and RMW latches.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_add     <= '0;
            r_be      <= '0;
            r_wdata   <= '0;
            r_rvalid  <= 1'b0;
            r_rd_resp <= 1'b0;
            r_err     <= 2'b00;
        end else begin
            r_rvalid  <= 1'b0;
            r_rd_resp <= 1'b0;
            r_err     <= 2'b00;
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_i) begin
                        if (!bus.we_i) begin
                            r_rvalid  <= 1'b1;
                            r_rd_resp <= 1'b1;
                        end else if (w_be_full || w_be_zero) begin
                            r_rvalid <= 1'b1;
                        end else begin
                            r_add   <= bus.add_i;
                            r_be    <= bus.be_i;
                            r_wdata <= bus.wdata_i;
                            r_state <= ST_MERGE;
                        end
                    end
                end
                ST_MERGE: begin
                    r_rvalid <= 1'b1;
                    r_err    <= w_dec_err;
                    r_add    <= '0;
                    r_be     <= '0;
                    r_wdata  <= '0;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Read responses decode the bank data live; write responses use r_err.
    assign bus.rvalid_o = r_rvalid;
    assign bus.rdata_o  = (r_rvalid && r_rd_resp) ? w_dec_data : '0;
    assign bus.err_o    = r_rd_resp ? w_dec_err : r_err;

    // Saturating error counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else if (cnt_clear_i) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else if (bus.rvalid_o) begin
            if (bus.err_o[0] && (r_corr_cnt != 16'hFFFF)) begin
                r_corr_cnt <= r_corr_cnt + 16'd1;
            end
            if (bus.err_o[1] && (r_uncorr_cnt != 16'hFFFF)) begin
                r_uncorr_cnt <= r_uncorr_cnt + 16'd1;
            end
        end
    end

    assign corr_cnt_o   = r_corr_cnt;
    assign uncorr_cnt_o = r_uncorr_cnt;
endmodule

// File: tb/tb_ecc_rmw_encoder.sv
// Scoreboard bench for ecc_rmw_encoder: a behavioural bank plus a golden
// word/error-mask model predict every bank access and response.
module tb_ecc_rmw_encoder;
    localparam int BS = 256;
    localparam int DW = 32;
    localparam int PW = 7;
    localparam int LW = DW + PW;
    localparam int AW = $clog2(BS);
    localparam int NB = DW / 8;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          bank_req, bank_we;
    logic [AW-1:0] bank_add;
    logic [LW-1:0] bank_wdata, bank_rdata;
    logic          cnt_clear = 1'b0;
    logic [15:0]   corr_cnt, uncorr_cnt;

    always #5 clk = ~clk;

    ecc_rmw_encoder_if #(.DataWidth(DW), .AddrWidth(AW)) bus ();

    ecc_rmw_encoder #(.BankSize(BS), .DataWidth(DW), .ProtWidth(PW)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .bus(bus.slave),
        .bank_req_o(bank_req), .bank_we_o(bank_we), .bank_add_o(bank_add),
        .bank_wdata_o(bank_wdata), .bank_rdata_i(bank_rdata),
        .cnt_clear_i(cnt_clear), .corr_cnt_o(corr_cnt), .uncorr_cnt_o(uncorr_cnt)
    );

    // Behavioural bank: one-cycle read latency, plus a back door for preloads.
    logic [LW-1:0] mem [BS];
    logic          pre_en = 1'b0;
    logic [AW-1:0] pre_add = '0;
    logic [LW-1:0] pre_line = '0;
    always @(posedge clk) begin
        if (bank_req && !bank_we) bank_rdata <= mem[bank_add];
        if (bank_req && bank_we) mem[bank_add] <= bank_wdata;
        if (pre_en) mem[pre_add] <= pre_line;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    logic [PW-1:0] cols [DW];
    logic [DW-1:0] gold [BS];
    logic [LW-1:0] gmask [BS];
    int  n_cmp = 0, n_fail = 0;
    int  exp_corr = 0, exp_uncorr = 0;
    bit  quiet = 1'b0;
    bit  rand_clear = 1'b0;

    typedef struct { int cyc; logic [DW-1:0] rdata; logic [1:0] err; } resp_t;
    typedef struct { int cyc; logic we; logic [AW-1:0] add; logic [LW-1:0] line; } bacc_t;
    resp_t resp_q[$];
    bacc_t bank_q[$];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void miss(input string name, input int exp_cyc);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: nothing seen, expected at cycle %0d (now %0d)", name, exp_cyc, cyc);
    endfunction

    // Codeword = data plus XOR of the H columns selected by the set data bits.
    function automatic logic [LW-1:0] encode(input logic [DW-1:0] d);
        logic [PW-1:0] c;
        c = '0;
        for (int i = 0; i < DW; i++) if (d[i]) c = c ^ cols[i];
        return {c, d};
    endfunction

    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_d, input logic [DW-1:0] new_d,
                                                  input logic [NB-1:0] be);
        logic [DW-1:0] m;
        m = old_d;
        for (int b = 0; b < NB; b++) if (be[b]) m[b*8 +: 8] = new_d[b*8 +: 8];
        return m;
    endfunction

    function automatic logic [LW-1:0] rand_mask(input int nbits);
        logic [LW-1:0] m;
        int p;
        m = '0;
        while ($countones(m) < nbits) begin
            p = $urandom_range(0, LW - 1);
            m[p] = 1'b1;
        end
        return m;
    endfunction

    // Issue one request, wait for its grant, then post the predictions.
    task automatic issue(input logic we, input logic [NB-1:0] be, input logic [AW-1:0] add,
                         input logic [DW-1:0] wdata, input bit abort_merge);
        int c, waits, nerr;
        resp_t r;
        bacc_t b;
        logic [DW-1:0] merged;
        @(negedge clk);
        bus.req_i = 1'b1; bus.we_i = we; bus.be_i = be; bus.add_i = add; bus.wdata_i = wdata;
        cnt_clear = rand_clear && ($urandom_range(0, 15) == 0);
        #1;
        waits = 0;
        while (!bus.gnt_o && waits < 8) begin
            @(negedge clk); #1;
            waits++;
        end
        if (!bus.gnt_o) begin
            check("grant_timeout", {63'b0, bus.gnt_o}, 64'd1);
            bus.req_i = 1'b0;
            return;
        end
        c = cyc;
        nerr = $countones(gmask[add]);
        r.cyc = c + 1; r.rdata = '0; r.err = 2'b00;
        if (!we) begin
            b.cyc = c; b.we = 1'b0; b.add = add; b.line = '0; bank_q.push_back(b);
            r.rdata = (nerr >= 2) ? (gold[add] ^ gmask[add][DW-1:0]) : gold[add];
            r.err   = (nerr == 0) ? 2'b00 : (nerr == 1) ? 2'b01 : 2'b10;
            resp_q.push_back(r);
        end else if (be == {NB{1'b1}}) begin
            b.cyc = c; b.we = 1'b1; b.add = add; b.line = encode(wdata); bank_q.push_back(b);
            gold[add] = wdata; gmask[add] = '0;
            resp_q.push_back(r);
        end else if (be == '0) begin
            resp_q.push_back(r);
        end else begin
            b.cyc = c; b.we = 1'b0; b.add = add; b.line = '0; bank_q.push_back(b);
            if (!abort_merge) begin
                r.cyc = c + 2;
                if (nerr >= 2) begin
                    r.err = 2'b10;
                end else begin
                    merged = merge_bytes(gold[add], wdata, be);
                    b.cyc = c + 1; b.we = 1'b1; b.add = add; b.line = encode(merged); bank_q.push_back(b);
                    gold[add] = merged; gmask[add] = '0;
                    r.err = (nerr == 1) ? 2'b01 : 2'b00;
                end
                resp_q.push_back(r);
            end
        end
        if (!quiet) $display("txn cyc=%0d we=%0b be=%b add=%0d wdata=%h stored_errs=%0d clr=%0b",
                             c, we, be, add, wdata, nerr, cnt_clear);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.req_i = 1'b0; cnt_clear = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Back-door store of a word with an injected flip mask, only while quiet.
    task automatic poke(input logic [AW-1:0] add, input logic [DW-1:0] d, input logic [LW-1:0] mask);
        idle(2);
        pre_en = 1'b1; pre_add = add; pre_line = encode(d) ^ mask;
        gold[add] = d; gmask[add] = mask;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    // Response monitor: pops the scoreboard and tracks the counters.
    initial begin
        resp_t e;
        bit got;
        forever begin
            @(negedge clk); #2;
            if (!rst_ni) begin
                exp_corr = 0; exp_uncorr = 0;
                check("rst_rvalid", {63'b0, bus.rvalid_o}, 64'd0);
            end else begin
                check("corr_cnt", corr_cnt, exp_corr);
                check("uncorr_cnt", uncorr_cnt, exp_uncorr);
                while (resp_q.size() > 0 && resp_q[0].cyc < cyc) begin
                    miss("resp_missing", resp_q[0].cyc);
                    void'(resp_q.pop_front());
                end
                got = 1'b0;
                if (bus.rvalid_o) begin
                    if (resp_q.size() == 0) begin
                        miss("resp_unexpected", -1);
                    end else begin
                        e = resp_q.pop_front();
                        got = 1'b1;
                        check("resp_cycle", cyc, e.cyc);
                        check("resp_rdata", bus.rdata_o, e.rdata);
                        check("resp_err", bus.err_o, e.err);
                    end
                end else begin
                    check("idle_rdata", bus.rdata_o, 64'd0);
                end
                if (cnt_clear) begin
                    exp_corr = 0; exp_uncorr = 0;
                end else if (got) begin
                    if (e.err[0] && exp_corr < 65535) exp_corr++;
                    if (e.err[1] && exp_uncorr < 65535) exp_uncorr++;
                end
            end
        end
    end

    // Bank monitor: every bank command must match a predicted access.
    initial begin
        bacc_t e;
        forever begin
            @(negedge clk); #2;
            if (!rst_ni) begin
                check("rst_bank_req", {63'b0, bank_req}, 64'd0);
            end else begin
                while (bank_q.size() > 0 && bank_q[0].cyc < cyc) begin
                    miss("bank_missing", bank_q[0].cyc);
                    void'(bank_q.pop_front());
                end
                if (bank_req) begin
                    if (bank_q.size() == 0) begin
                        miss("bank_unexpected", -1);
                    end else begin
                        e = bank_q.pop_front();
                        check("bank_cycle", cyc, e.cyc);
                        check("bank_we", {63'b0, bank_we}, {63'b0, e.we});
                        check("bank_add", bank_add, e.add);
                        if (e.we) check("bank_wdata", bank_wdata, e.line);
                    end
                end else begin
                    check("idle_bank_add", bank_add, 64'd0);
                    check("idle_bank_wdata", bank_wdata, 64'd0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Main stimulus
    initial begin
        int k;
        logic [PW-1:0] vv;
        logic [DW-1:0] d;
        int op;
        logic [AW-1:0] a;
        bus.req_i = 1'b0; bus.we_i = 1'b0; bus.be_i = '0; bus.add_i = '0; bus.wdata_i = '0;
        k = 0;
        for (int v = 0; v < (1 << PW); v++) begin
            vv = v[PW-1:0];
            if ($countones(vv) == 3 && k < DW) begin
                cols[k] = vv;
                k++;
            end
        end

        // Preload the whole bank while reset is held.
        for (int i = 0; i < BS; i++) begin
            @(negedge clk);
            d = $urandom;
            if (i == 5) d = 32'hDEADBEEF;
            if (i == 9) d = 32'h11223344;
            a = i[AW-1:0];
            pre_en = 1'b1; pre_add = a; pre_line = encode(d);
            gold[i] = d; gmask[i] = '0;
        end
        @(negedge clk);
        pre_en = 1'b0;
        bus.req_i = 1'b1; bus.we_i = 1'b0;
        #1;
        check("rst_gnt", {63'b0, bus.gnt_o}, 64'd0);
        check("rst_corr_cnt", corr_cnt, 64'd0);
        check("rst_err", bus.err_o, 64'd0);
        @(negedge clk);
        bus.req_i = 1'b0;
        rst_ni = 1'b1;

        // Clean read, then a single-bit flip at bit 3 read twice.
        issue(1'b0, '0, 8'd5, '0, 1'b0);
        poke(8'd5, 32'hDEADBEEF, 39'h8);
        issue(1'b0, '0, 8'd5, '0, 1'b0);
        idle(3); #3;
        check("corr_after_flip", corr_cnt, 64'd1);
        issue(1'b0, '0, 8'd5, '0, 1'b0);

        // Partial write into a clean word, then read it back.
        issue(1'b1, 4'b0010, 8'd9, 32'h0000AA00, 1'b0);
        issue(1'b0, '0, 8'd9, '0, 1'b0);

        // Partial write over a double-bit error: no write, uncorrectable.
        poke(8'd12, 32'hCAFEF00D, 39'h0_0010_0001);
        issue(1'b1, 4'b0001, 8'd12, 32'h00000055, 1'b0);
        idle(3); #3;
        check("uncorr_after_dbl", uncorr_cnt, 64'd1);
        issue(1'b0, '0, 8'd12, '0, 1'b0);

        // Full and zero-byte writes back to back with reads.
        issue(1'b1, 4'b1111, 8'd7, 32'h01234567, 1'b0);
        issue(1'b0, '0, 8'd7, '0, 1'b0);
        issue(1'b1, 4'b0000, 8'd7, 32'hFFFFFFFF, 1'b0);
        issue(1'b0, '0, 8'd7, '0, 1'b0);

        // Randomised traffic over a small address window with injected errors.
        rand_clear = 1'b1;
        for (int round = 0; round < 8; round++) begin
            a = 8'($urandom_range(0, 15));
            poke(a, $urandom, rand_mask($urandom_range(0, 2)));
            for (int t = 0; t < 40; t++) begin
                op = $urandom_range(0, 9);
                a = 8'($urandom_range(0, 15));
                d = $urandom;
                if (op < 4)      issue(1'b0, 4'($urandom), a, d, 1'b0);
                else if (op < 6) issue(1'b1, 4'b1111, a, d, 1'b0);
                else if (op < 9) issue(1'b1, 4'($urandom_range(1, 14)), a, d, 1'b0);
                else             issue(1'b1, 4'b0000, a, d, 1'b0);
            end
        end
        rand_clear = 1'b0;

        // Saturate the corrected counter with a stream of corrected reads.
        idle(1);
        cnt_clear = 1'b1;
        @(negedge clk);
        cnt_clear = 1'b0;
        poke(8'd20, 32'h5A5A0F0F, 39'h80);
        quiet = 1'b1;
        for (int i = 0; i < 65540; i++) issue(1'b0, '0, 8'd20, '0, 1'b0);
        quiet = 1'b0;
        $display("txn burst: 65540 corrected reads of addr 20");
        idle(3); #3;
        check("corr_saturated", corr_cnt, 64'hFFFF);

        // Clear in the same cycle as a corrected response.
        issue(1'b0, '0, 8'd20, '0, 1'b0);
        @(negedge clk);
        bus.req_i = 1'b0; cnt_clear = 1'b1;
        @(negedge clk);
        cnt_clear = 1'b0;
        #3;
        check("corr_clear_priority", corr_cnt, 64'd0);

        // Reset during Merge abandons the read-modify-write.
        poke(8'd30, 32'h0BADF00D, '0);
        issue(1'b1, 4'b0100, 8'd30, 32'h00770000, 1'b1);
        @(negedge clk);
        rst_ni = 1'b0;
        #1;
        check("mrst_gnt", {63'b0, bus.gnt_o}, 64'd0);
        check("mrst_bank_we", {63'b0, bank_we}, 64'd0);
        check("mrst_rvalid", {63'b0, bus.rvalid_o}, 64'd0);
        check("mrst_err", bus.err_o, 64'd0);
        check("mrst_rdata", bus.rdata_o, 64'd0);
        @(negedge clk);
        bus.req_i = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        issue(1'b0, '0, 8'd30, '0, 1'b0);
        idle(4);

        check("resp_q_drained", resp_q.size(), 64'd0);
        check("bank_q_drained", bank_q.size(), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
